cylon_mode_ctrl: RTL and testbench
==================================

# cylon_mode_ctrl

Upstream control stage for the cylon LED sequencer. It synchronises and debounces the three push buttons (btnC, btnL, btnR) and converts debounced presses into one-cycle press pulses. It holds the 2-bit movement mode register that drives the sequencer's `mode` input. It replaces the direct raw-button mode logic in the top level, so metastable or bouncing inputs can no longer corrupt the mode.

## Interface
Parameters
- DEBOUNCE_CYCLES, 20'd1_000_000 — consecutive cycles a synchronised button must differ from its debounced state before the state flips (10 ms at 100 MHz); legal range 1 .. 2^CNT_WIDTH-1.
- CNT_WIDTH, 20 — width of each debounce counter.

Ports
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- btnC  in  1  raw centre button; asynchronous, bouncing.
- btnL  in  1  raw left button; asynchronous, bouncing.
- btnR  in  1  raw right button; asynchronous, bouncing.
- mode  out  2  current mode: 2'b00 cylon, 2'b01 right-to-left, 2'b10 left-to-right; 2'b11 is never produced.
- mode_changed  out  1  one-cycle pulse in the cycle `mode` takes a new value.
- btn_state  out  3  debounced levels, {R, L, C}.
- btn_press  out  3  one-cycle debounced rising-edge pulses, {R, L, C}.

## Operation
- **Reset.** While rst_n is low, all sync flops, counters, btn_state, btn_press, mode_changed = 0 and mode = 2'b00, asynchronously.
- **Synchroniser.** Each button passes through a 2-flop synchroniser (s1, s2). Only s2 is used downstream.
- **Debouncer.** Each button has an independent counter `cnt` and a debounced level `d`.
  - If s2 == d: cnt <= 0.
  - If s2 != d and cnt == DEBOUNCE_CYCLES-1: d <= s2, cnt <= 0.
  - Otherwise (s2 != d): cnt <= cnt + 1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles resets the count and never changes d.
- **Press pulse.** btn_press[i] is registered. It is high for exactly the one cycle in which d[i] first reads 1 after a 0→1 update.
  - Releases (1→0) update btn_state only and produce no pulse.
  - A held button yields exactly one pulse.
- **Mode register.** It updates on the edge after a press pulse. Priority on simultaneous pulses: C → 2'b00, else R → 2'b10, else L → 2'b01.
  - If no pulse is present, mode holds.
- **mode_changed.** Registered alongside mode. High for one cycle only when the new value differs from the old one. Pressing the button of the already-active mode produces no mode_changed.
- **Reset mid-operation.** All state clears. A button held across rst_n deassertion is treated as a new press and is debounced from zero.

## Timing
- Let edge 0 be the first clk rising edge at which a raw button is high and stable.
  - s2 is high after edge 1.
  - The counter runs over edges 2 .. DEBOUNCE_CYCLES+1.
  - btn_state and btn_press go high after edge DEBOUNCE_CYCLES+1.
  - mode and mode_changed update after edge DEBOUNCE_CYCLES+2.
- Total latency from raw press to the new mode: DEBOUNCE_CYCLES+3 edges.
- Release latency to btn_state low: DEBOUNCE_CYCLES+2 edges.
- DEBOUNCE_CYCLES = 1: d follows s2 with one cycle delay and no filtering.
- Counters never exceed DEBOUNCE_CYCLES-1, so there is no wrap-around.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench configuration: DEBOUNCE_CYCLES = 4, CNT_WIDTH = 3.
- **Reset values.** Hold rst_n low with all buttons high → mode = 00, btn_state = 000, btn_press = 000, mode_changed = 0. Release rst_n with btnR held → btn_press[2] pulses after edge 5, mode = 10 and mode_changed = 1 after edge 6.
- **Clean press.** Press btnL (held 20 cycles) from mode 00 → exactly one btn_press[1] pulse, mode = 01, one mode_changed pulse. Release → btn_state[1] returns to 0 six edges after the release, with no pulse.
- **Bounce rejection.**
  - btnC toggles high 3 cycles, low 1 cycle, repeated 5 times → btn_state and btn_press stay 0 and mode is unchanged.
  - btnC then held 4+ cycles → one press.
- **Simultaneous press.**
  - btnL and btnR rise on the same edge from mode 00 → mode = 10 (R wins).
  - All three rise on the same edge from mode 10 → mode = 00 with mode_changed = 1.
- **Same-mode press.** In mode 01, press btnL → btn_press[1] pulses, mode stays 01, mode_changed stays 0.
- **Asynchronous reset mid-count.** btnR high and the counter at 2, assert rst_n for 1 ns between edges → mode = 00 and counters = 0 immediately. After release with btnR still held, the full 6-edge latency restarts.

Source files
------------

// File: rtl/cylon_mode_ctrl.sv
// Button conditioning and mode register for the cylon LED sequencer.
// Each button is synchronised, debounced and edge-detected before it can touch the mode.

module cylon_debounce #(
    parameter int                   CNT_WIDTH = 20,
    parameter logic [CNT_WIDTH-1:0] CNT_LAST  = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);
    logic                 s1, s2;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s2;
                cnt   <= '0;
                // pulse only on the 0->1 flip; releases are silent
                press <= s2;
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end
endmodule

module cylon_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int          CNT_WIDTH       = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnC,
    input  logic       btnL,
    input  logic       btnR,
    output logic [1:0] mode,
    output logic       mode_changed,
    output logic [2:0] btn_state,
    output logic [2:0] btn_press
);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        CYLON = 2'b00,
        R2L   = 2'b01,
        L2R   = 2'b10
    } mode_t;

    mode_t state;

    // bit order {R, L, C} matches btn_state / btn_press
    cylon_debounce #(
        .CNT_WIDTH (CNT_WIDTH),
        .CNT_LAST  (CNT_LAST)
    ) u_db [2:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   ({btnR, btnL, btnC}),
        .level (btn_state),
        .press (btn_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CYLON;
            mode_changed <= 1'b0;
        end else begin
            mode_changed <= 1'b0;
            if (btn_press[0]) begin
                state        <= CYLON;
                mode_changed <= (state != CYLON);
            end else if (btn_press[2]) begin
                state        <= L2R;
                mode_changed <= (state != L2R);
            end else if (btn_press[1]) begin
                state        <= R2L;
                mode_changed <= (state != R2L);
            end
        end
    end

    assign mode = state;
endmodule

// File: tb/tb_cylon_mode_ctrl.sv
// Randomised and directed checks of cylon_mode_ctrl against a history-based model
// (a debounced level flips when the last DEB synchronised samples all disagree with it).
module tb_cylon_mode_ctrl;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btnC = 1'b0, btnL = 1'b0, btnR = 1'b0;
    logic [1:0] mode;
    logic       mode_changed;
    logic [2:0] btn_state, btn_press;

    int total = 0;
    int bad   = 0;

    cylon_mode_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btnC         (btnC),
        .btnL         (btnL),
        .btnR         (btnR),
        .mode         (mode),
        .mode_changed (mode_changed),
        .btn_state    (btn_state),
        .btn_press    (btn_press)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [2:0] rawq[$];
    logic [2:0] s2q[$];
    logic [2:0] exp_state, exp_press;
    logic [1:0] exp_mode;
    logic       exp_mc;

    task automatic model_reset();
        rawq.delete();
        s2q.delete();
        exp_state = '0;
        exp_press = '0;
        exp_mode  = 2'b00;
        exp_mc    = 1'b0;
    endtask

    task automatic model_edge(input logic [2:0] b);
        logic [2:0] s2v, np;
        logic [1:0] nm;
        logic       all;
        // the synchronised value seen at this edge is the raw sample from two edges ago
        s2v = (rawq.size() >= 2) ? rawq[rawq.size()-2] : 3'b000;
        rawq.push_back(b);
        s2q.push_back(s2v);
        if (exp_press[0])      nm = 2'b00;
        else if (exp_press[2]) nm = 2'b10;
        else if (exp_press[1]) nm = 2'b01;
        else                   nm = exp_mode;
        exp_mc   = (nm != exp_mode);
        exp_mode = nm;
        np = '0;
        for (int i = 0; i < 3; i++) begin
            if (s2q.size() >= DEB) begin
                all = 1'b1;
                for (int k = 1; k <= DEB; k++)
                    if (s2q[s2q.size()-k][i] == exp_state[i]) all = 1'b0;
                if (all) begin
                    exp_state[i] = ~exp_state[i];
                    np[i] = exp_state[i];
                end
            end
        end
        exp_press = np;
    endtask

    function automatic logic [7:0] got();
        return {mode, mode_changed, btn_state, btn_press};
    endfunction

    function automatic logic [7:0] expv();
        return {exp_mode, exp_mc, exp_state, exp_press};
    endfunction

    // drive inputs 1 ns after an edge, clock them in, advance the model
    task automatic step(input logic [2:0] b);
        {btnR, btnL, btnC} = b;
        @(posedge clk);
        model_edge(b);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        {btnR, btnL, btnC} = 3'b111;
        repeat (3) @(negedge clk);
        total++;
        if (got() !== 8'h00) begin
            bad++;
            $display("FAIL reset_values: got %b exp %b", got(), 8'h00);
        end
        rst_n = 1'b1;
        for (int e = 0; e < 9; e++) begin
            step(3'b100);
            total++;
            if (got() !== expv()) begin
                bad++;
                $display("FAIL reset_release e%0d: got %b exp %b", e, got(), expv());
            end
            if (e == 5) begin
                total++;
                if (btn_press !== 3'b100) begin
                    bad++;
                    $display("FAIL reset_press_edge5: got %b exp 100", btn_press);
                end
            end
            if (e == 6) begin
                total++;
                if ({mode, mode_changed} !== 3'b101) begin
                    bad++;
                    $display("FAIL reset_mode_edge6: got %b exp 101", {mode, mode_changed});
                end
            end
        end
        for (int e = 0; e < 8; e++) begin
            step(3'b000);
            total++;
            if (got() !== expv()) begin
                bad++;
                $display("FAIL reset_idle e%0d: got %b exp %b", e, got(), expv());
            end
        end
    endtask

    task automatic test_bounce();
        int np = 0;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                step(k < 3 ? 3'b001 : 3'b000);
                total++;
                if (got() !== expv() || btn_state[0] !== 1'b0 || btn_press[0] !== 1'b0 || mode !== 2'b10) begin
                    bad++;
                    $display("FAIL bounce r%0d k%0d: got %b exp %b", r, k, got(), expv());
                end
            end
        end
        for (int e = 0; e < 10; e++) begin
            step(3'b001);
            np += btn_press[0];
            total++;
            if (got() !== expv()) begin
                bad++;
                $display("FAIL bounce_hold e%0d: got %b exp %b", e, got(), expv());
            end
        end
        total++;
        if (np != 1 || mode !== 2'b00) begin
            bad++;
            $display("FAIL bounce_result: got presses=%0d mode=%b exp presses=1 mode=00", np, mode);
        end
        for (int e = 0; e < 8; e++) step(3'b000);
    endtask

    task automatic test_clean_press();
        int np = 0, nmc = 0;
        for (int e = 0; e < 20; e++) begin
            step(3'b010);
            np  += btn_press[1];
            nmc += mode_changed;
            total++;
            if (got() !== expv()) begin
                bad++;
                $display("FAIL clean e%0d: got %b exp %b", e, got(), expv());
            end
        end
        total++;
        if (np != 1 || nmc != 1 || mode !== 2'b01) begin
            bad++;
            $display("FAIL clean_result: got p=%0d mc=%0d mode=%b exp p=1 mc=1 mode=01", np, nmc, mode);
        end
        for (int e = 0; e < 10; e++) begin
            step(3'b000);
            total++;
            if (got() !== expv() || btn_press !== 3'b000
                || (e == 4 && btn_state[1] !== 1'b1) || (e == 5 && btn_state[1] !== 1'b0)) begin
                bad++;
                $display("FAIL clean_release e%0d: got %b exp %b", e, got(), expv());
            end
        end
    endtask

    task automatic test_same_mode();
        int np = 0, nmc = 0;
        for (int e = 0; e < 12; e++) begin
            step(3'b010);
            np  += btn_press[1];
            nmc += mode_changed;
            total++;
            if (got() !== expv()) begin
                bad++;
                $display("FAIL same_mode e%0d: got %b exp %b", e, got(), expv());
            end
        end
        total++;
        if (np != 1 || nmc != 0 || mode !== 2'b01) begin
            bad++;
            $display("FAIL same_mode_result: got p=%0d mc=%0d mode=%b exp p=1 mc=0 mode=01", np, nmc, mode);
        end
        for (int e = 0; e < 10; e++) step(3'b000);
    endtask

    task automatic test_simultaneous();
        int nmc;
        logic [2:0] pat [4] = '{3'b001, 3'b110, 3'b000, 3'b111};
        logic [1:0] want[4] = '{2'b00, 2'b10, 2'b10, 2'b00};
        for (int p = 0; p < 4; p++) begin
            nmc = 0;
            for (int e = 0; e < 10; e++) begin
                step(pat[p]);
                nmc += mode_changed;
                total++;
                if (got() !== expv()) begin
                    bad++;
                    $display("FAIL simul p%0d e%0d: got %b exp %b", p, e, got(), expv());
                end
            end
            total++;
            if (mode !== want[p] || (p == 3 && nmc != 1)) begin
                bad++;
                $display("FAIL simul_result p%0d: got mode=%b mc=%0d exp mode=%b", p, mode, nmc, want[p]);
            end
            for (int e = 0; e < 10; e++) step(3'b000);
        end
    endtask

    task automatic test_async_reset();
        for (int e = 0; e < 12; e++) step(3'b010);
        for (int e = 0; e < 10; e++) step(3'b000);
        for (int e = 0; e < 4; e++) step(3'b100);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (got() !== 8'h00) begin
            bad++;
            $display("FAIL async_reset_clear: got %b exp %b", got(), 8'h00);
        end
        model_reset();
        #1 rst_n = 1'b1;
        for (int e = 0; e < 9; e++) begin
            step(3'b100);
            total++;
            if (got() !== expv() || (e == 4 && btn_press[2] !== 1'b0) || (e == 5 && btn_press[2] !== 1'b1)
                || (e == 6 && {mode, mode_changed} !== 3'b101)) begin
                bad++;
                $display("FAIL async_restart e%0d: got %b exp %b", e, got(), expv());
            end
        end
        for (int e = 0; e < 8; e++) step(3'b000);
    endtask

    task automatic test_random();
        logic [2:0] b = 3'b000;
        int rem[3] = '{1, 1, 1};
        for (int e = 0; e < 400; e++) begin
            for (int i = 0; i < 3; i++) begin
                rem[i]--;
                if (rem[i] <= 0) begin
                    b[i]   = $urandom_range(0, 1);
                    rem[i] = $urandom_range(1, 8);
                end
            end
            step(b);
            total++;
            if (got() !== expv()) begin
                bad++;
                $display("FAIL random e%0d: got %b exp %b", e, got(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_clean_press();
        test_same_mode();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
